// File: rtl/vga_arb_pkg.sv
// Shared types and constants for the VGA framebuffer write-port arbiter.
// Requester indices name the producers wired to the arbiter inputs.
package vga_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWNED = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

  localparam int DEF_X_W     = 9;
  localparam int DEF_Y_W     = 8;
  localparam int DEF_COLOR_W = 3;

  localparam int REQ_BG     = 0;
  localparam int REQ_SPRITE = 1;
  localparam int REQ_ANIM   = 2;

  localparam int MAX_REQ = 8;

  // Index of the set bit of a one-hot vector (zero when none is set).
  function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < MAX_REQ; i++) begin
      idx = idx | (oh[i] ? 3'(i) : 3'd0);
    end
    return idx;
  endfunction

endpackage

// File: rtl/vga_write_arbiter_rr_picker.sv
// Combinational round-robin picker: the search starts one past the last owner
// and wraps, so the most recent owner has the lowest priority.
module rr_picker #(
  parameter int N  = 3,
  parameter int LW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [LW-1:0] last_owner_i,
  output logic [N-1:0]  winner_o,
  output logic          valid_o
);

  logic [N-1:0]  win;
  logic          found;
  logic [LW-1:0] idx;

  // First requester after last_owner in circular order wins.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = LW'((int'(last_owner_i) + k) % N);
      if (!found && req_i[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end else begin
        found = found;
      end
    end
  end

  assign winner_o = win;
  assign valid_o  = found;

endmodule

// File: rtl/vga_write_arbiter.sv
// Round-robin owner of the single VGA framebuffer write port. Only the current
// owner's pixels reach the adapter, through one register stage.
module vga_write_arbiter
  import vga_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int X_W     = DEF_X_W,
  parameter int Y_W     = DEF_Y_W,
  parameter int COLOR_W = DEF_COLOR_W
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  output logic [NUM_REQ-1:0]           grant,
  input  logic [NUM_REQ-1:0]           pix_valid,
  input  logic [NUM_REQ*X_W-1:0]       pix_x,
  input  logic [NUM_REQ*Y_W-1:0]       pix_y,
  input  logic [NUM_REQ*COLOR_W-1:0]   pix_color,
  output logic                         vga_plot,
  output logic [X_W-1:0]               vga_x,
  output logic [Y_W-1:0]               vga_y,
  output logic [COLOR_W-1:0]           vga_color,
  output logic                         busy,
  output logic                         drop_err
);

  localparam int LW = $clog2(NUM_REQ);
  localparam logic [LW-1:0] LAST_RST = LW'(NUM_REQ - 1);

  arb_state_e           state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [LW-1:0]        last_owner_q, last_owner_d;
  logic                 plot_q, plot_d;
  logic [X_W-1:0]       x_q, x_d;
  logic [Y_W-1:0]       y_q, y_d;
  logic [COLOR_W-1:0]   color_q, color_d;
  logic                 busy_q;
  logic                 drop_q, drop_d;

  logic [NUM_REQ-1:0]   pick_oh;
  logic                 pick_valid;
  logic [NUM_REQ-1:0]   accept;

  rr_picker #(
    .N  (NUM_REQ),
    .LW (LW)
  ) u_picker (
    .req_i        (req),
    .last_owner_i (last_owner_q),
    .winner_o     (pick_oh),
    .valid_o      (pick_valid)
  );

  assign accept = grant_q & pix_valid;

  // Ownership FSM: grant is only ever non-zero in OWNED.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_owner_d = last_owner_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d      = pick_oh;
          last_owner_d = LW'(onehot_to_idx(MAX_REQ'(pick_oh)));
          state_d      = OWNED;
        end else begin
          grant_d = '0;
        end
      end
      OWNED: begin
        if (~|(req & grant_q)) begin
          grant_d = '0;
          state_d = GAP;
        end else begin
          grant_d = grant_q;
        end
      end
      GAP: begin
        grant_d = '0;
        state_d = IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Pixel path: forward the owner's fields, hold coordinates when idle.
  always_comb begin
    plot_d  = |accept;
    x_d     = x_q;
    y_d     = y_q;
    color_d = color_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept[i]) begin
        x_d     = pix_x[i*X_W +: X_W];
        y_d     = pix_y[i*Y_W +: Y_W];
        color_d = pix_color[i*COLOR_W +: COLOR_W];
      end else begin
        x_d = x_d;
      end
    end
    drop_d = drop_q | (|(pix_valid & ~grant_q));
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_owner_q <= LAST_RST;
      plot_q       <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      color_q      <= '0;
      busy_q       <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_owner_q <= last_owner_d;
      plot_q       <= plot_d;
      x_q          <= x_d;
      y_q          <= y_d;
      color_q      <= color_d;
      busy_q       <= |grant_d;
      drop_q       <= drop_d;
    end
  end

  assign grant     = grant_q;
  assign vga_plot  = plot_q;
  assign vga_x     = x_q;
  assign vga_y     = y_q;
  assign vga_color = color_q;
  assign busy      = busy_q;
  assign drop_err  = drop_q;

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Directed self-checking bench for vga_write_arbiter (3 requesters, 320x240).
module tb_vga_write_arbiter;
  import vga_arb_pkg::*;

  logic        clock;
  logic        reset;
  logic [2:0]  req;
  logic [2:0]  grant;
  logic [2:0]  pix_valid;
  logic [26:0] pix_x;
  logic [23:0] pix_y;
  logic [8:0]  pix_color;
  logic        vga_plot;
  logic [8:0]  vga_x;
  logic [7:0]  vga_y;
  logic [2:0]  vga_color;
  logic        busy;
  logic        drop_err;

  int checks;
  int fails;

  vga_write_arbiter #(
    .NUM_REQ (3),
    .X_W     (9),
    .Y_W     (8),
    .COLOR_W (3)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .grant     (grant),
    .pix_valid (pix_valid),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_color (pix_color),
    .vga_plot  (vga_plot),
    .vga_x     (vga_x),
    .vga_y     (vga_y),
    .vga_color (vga_color),
    .busy      (busy),
    .drop_err  (drop_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_pix(input int i, input logic [8:0] x, input logic [7:0] y, input logic [2:0] c);
    pix_x[i*9 +: 9]     = x;
    pix_y[i*8 +: 8]     = y;
    pix_color[i*3 +: 3] = c;
    pix_valid[i]        = 1'b1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req       = 3'b000;
    pix_valid = 3'b000;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req       = 3'b000;
    pix_valid = 3'b000;
    pix_x     = 27'd0;
    pix_y     = 24'd0;
    pix_color = 9'd0;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if ({grant, vga_plot, busy, drop_err, vga_x, vga_y, vga_color} !== 26'd0) begin
      $display("FAIL reset_state: got grant=%b plot=%b busy=%b drop=%b x=%0d y=%0d c=%0d, expected all zero",
               grant, vga_plot, busy, drop_err, vga_x, vga_y, vga_color);
      fails++;
    end
  endtask

  task automatic test_single_owner();
    req = 3'b001;
    tick();
    checks++;
    if (grant !== 3'b001 || busy !== 1'b1) begin
      $display("FAIL single_grant: got grant=%b busy=%b, expected 001 busy=1", grant, busy);
      fails++;
    end
    for (int j = 0; j < 4; j++) begin
      set_pix(REQ_BG, 9'(j), 8'd0, 3'b111);
      tick();
      checks++;
      if ({vga_plot, vga_x, vga_y, vga_color} !== {1'b1, 9'(j), 8'd0, 3'b111}) begin
        $display("FAIL single_pixel%0d: got plot=%b x=%0d y=%0d c=%0d, expected plot=1 x=%0d y=0 c=7",
                 j, vga_plot, vga_x, vga_y, vga_color, j);
        fails++;
      end
    end
    pix_valid = 3'b000;
    tick();
    checks++;
    if (vga_plot !== 1'b0 || vga_x !== 9'd3) begin
      $display("FAIL single_hold: got plot=%b x=%0d, expected plot=0 x=3", vga_plot, vga_x);
      fails++;
    end
    req = 3'b000;
    tick();
    tick();
    checks++;
    if (grant !== 3'b000 || busy !== 1'b0) begin
      $display("FAIL single_release: got grant=%b busy=%b, expected 000 busy=0", grant, busy);
      fails++;
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g;
    do_reset();
    req = 3'b111;
    tick();
    for (int k = 0; k < 3; k++) begin
      exp_g = 3'b001 << k;
      checks++;
      if (grant !== exp_g) begin
        $display("FAIL rr_grant%0d: got %b, expected %b", k, grant, exp_g);
        fails++;
      end
      for (int j = 0; j < 2; j++) begin
        set_pix(k, 9'(20*k + j), 8'(k), 3'(k + 1));
        tick();
        checks++;
        if ({vga_plot, vga_x, vga_y} !== {1'b1, 9'(20*k + j), 8'(k)}) begin
          $display("FAIL rr_pixel%0d_%0d: got plot=%b x=%0d y=%0d, expected plot=1 x=%0d y=%0d",
                   k, j, vga_plot, vga_x, vga_y, 20*k + j, k);
          fails++;
        end
      end
      pix_valid = 3'b000;
      req[k]    = 1'b0;
      tick();
      checks++;
      if (grant !== 3'b000 || vga_plot !== 1'b0) begin
        $display("FAIL rr_dead1_%0d: got grant=%b plot=%b, expected 000 plot=0", k, grant, vga_plot);
        fails++;
      end
      tick();
      checks++;
      if (grant !== 3'b000) begin
        $display("FAIL rr_dead2_%0d: got grant=%b, expected 000", k, grant);
        fails++;
      end
      tick();
    end
    checks++;
    if (grant !== 3'b000 || drop_err !== 1'b0) begin
      $display("FAIL rr_end: got grant=%b drop=%b, expected 000 drop=0", grant, drop_err);
      fails++;
    end
  endtask

  task automatic test_no_preempt();
    do_reset();
    req = 3'b010;
    tick();
    checks++;
    if (grant !== 3'b010) begin
      $display("FAIL np_grant: got %b, expected 010", grant);
      fails++;
    end
    req = 3'b011;
    for (int j = 0; j < 3; j++) begin
      tick();
      checks++;
      if (grant !== 3'b010) begin
        $display("FAIL np_hold%0d: got %b, expected 010", j, grant);
        fails++;
      end
    end
    req = 3'b001;
    tick();
    tick();
    checks++;
    if (grant !== 3'b000) begin
      $display("FAIL np_gap: got %b, expected 000", grant);
      fails++;
    end
    tick();
    checks++;
    if (grant !== 3'b001) begin
      $display("FAIL np_next: got %b, expected 001", grant);
      fails++;
    end
  endtask

  task automatic test_drop();
    do_reset();
    req = 3'b001;
    tick();
    set_pix(REQ_BG, 9'd5, 8'd6, 3'b010);
    set_pix(REQ_ANIM, 9'd319, 8'd239, 3'b101);
    tick();
    checks++;
    if ({vga_plot, vga_x, vga_y, vga_color, drop_err} !== {1'b1, 9'd5, 8'd6, 3'b010, 1'b1}) begin
      $display("FAIL drop_pixel: got plot=%b x=%0d y=%0d c=%0d drop=%b, expected plot=1 x=5 y=6 c=2 drop=1",
               vga_plot, vga_x, vga_y, vga_color, drop_err);
      fails++;
    end
    pix_valid = 3'b100;
    pix_valid[REQ_BG] = 1'b0;
    tick();
    checks++;
    if (vga_plot !== 1'b0 || vga_x !== 9'd5) begin
      $display("FAIL drop_discard: got plot=%b x=%0d, expected plot=0 x=5", vga_plot, vga_x);
      fails++;
    end
    pix_valid = 3'b000;
    tick();
    tick();
    checks++;
    if (drop_err !== 1'b1) begin
      $display("FAIL drop_sticky: got %b, expected 1", drop_err);
      fails++;
    end
  endtask

  task automatic test_reset_mid_pass();
    do_reset();
    req = 3'b010;
    tick();
    pix_valid = 3'b001;
    tick();
    checks++;
    if (drop_err !== 1'b1 || grant !== 3'b010) begin
      $display("FAIL rst_pre: got drop=%b grant=%b, expected drop=1 grant=010", drop_err, grant);
      fails++;
    end
    pix_valid = 3'b000;
    set_pix(REQ_SPRITE, 9'd7, 8'd8, 3'b011);
    reset = 1'b1;
    tick();
    checks++;
    if ({grant, vga_plot, busy, drop_err} !== 6'd0) begin
      $display("FAIL rst_mid: got grant=%b plot=%b busy=%b drop=%b, expected all zero",
               grant, vga_plot, busy, drop_err);
      fails++;
    end
    reset     = 1'b0;
    pix_valid = 3'b000;
    req       = 3'b011;
    tick();
    checks++;
    if (grant !== 3'b001) begin
      $display("FAIL rst_after: got %b, expected 001", grant);
      fails++;
    end
  endtask

  task automatic test_gap_rerequest();
    do_reset();
    req = 3'b001;
    tick();
    req = 3'b011;
    tick();
    checks++;
    if (grant !== 3'b001) begin
      $display("FAIL gap_owner: got %b, expected 001", grant);
      fails++;
    end
    req = 3'b010;
    tick();
    req = 3'b011;
    set_pix(REQ_BG, 9'd100, 8'd50, 3'b001);
    tick();
    checks++;
    if (grant !== 3'b000 || vga_plot !== 1'b0 || drop_err !== 1'b1) begin
      $display("FAIL gap_drop: got grant=%b plot=%b drop=%b, expected 000 plot=0 drop=1",
               grant, vga_plot, drop_err);
      fails++;
    end
    pix_valid = 3'b000;
    tick();
    checks++;
    if (grant !== 3'b010) begin
      $display("FAIL gap_next: got %b, expected 010", grant);
      fails++;
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_single_owner();
    test_round_robin();
    test_no_preempt();
    test_drop();
    test_reset_mid_pass();
    test_gap_rerequest();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
